// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller. It counts down each phase on rising edges
// of the 1 Hz level input and supports an emergency all-red override and a hold input.
module traffic_light_ctrl #(
  parameter int unsigned T_MG = 30,
  parameter int unsigned T_MY = 3,
  parameter int unsigned T_AR = 2,
  parameter int unsigned T_SG = 20,
  parameter int unsigned T_SY = 3
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       clk_1024,
  input  logic       emg,
  input  logic       hold,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [2:0] state_o
);

  localparam int unsigned CW = 7;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_SG  = 3'd3,
    S_SY  = 3'd4,
    S_AR2 = 3'd5,
    S_EMG = 3'd6,
    S_BAD = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    side_q, side_d;
  logic          tick_q;
  logic          rise;

  function automatic state_e next_phase(input state_e s);
    case (s)
      S_MG:    return S_MY;
      S_MY:    return S_AR1;
      S_AR1:   return S_SG;
      S_SG:    return S_SY;
      S_SY:    return S_AR2;
      default: return S_MG;
    endcase
  endfunction

  function automatic logic [CW-1:0] phase_len(input state_e s);
    case (s)
      S_MY:          return CW'(T_MY);
      S_AR1, S_AR2:  return CW'(T_AR);
      S_SG:          return CW'(T_SG);
      S_SY:          return CW'(T_SY);
      default:       return CW'(T_MG);
    endcase
  endfunction

  assign rise = clk_1024 & ~tick_q;

  // Phase sequencing: emg overrides everything, EMG exit discards a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (emg) begin
      state_d = S_EMG;
      cnt_d   = '0;
    end else if (state_q == S_EMG) begin
      state_d = S_AR2;
      cnt_d   = phase_len(S_AR2);
    end else if (state_q == S_BAD) begin
      state_d = S_MG;
      cnt_d   = phase_len(S_MG);
    end else if (!hold && rise) begin
      if (cnt_q == CW'(1)) begin
        state_d = next_phase(state_q);
        cnt_d   = phase_len(next_phase(state_q));
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Lamp decode from the next state so the lamp flops track state_q exactly.
  always_comb begin
    main_d = LAMP_R;
    side_d = LAMP_R;
    case (state_d)
      S_MG:    main_d = LAMP_G;
      S_MY:    main_d = LAMP_Y;
      S_SG:    side_d = LAMP_G;
      S_SY:    side_d = LAMP_Y;
      default: ;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= S_MG;
      cnt_q   <= CW'(T_MG);
      tick_q  <= 1'b0;
      main_q  <= LAMP_G;
      side_q  <= LAMP_R;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= clk_1024;
      main_q  <= main_d;
      side_q  <= side_d;
    end
  end

  assign main_rgy = main_q;
  assign side_rgy = side_q;
  assign state_o  = state_q;
  assign cnt_tens = 4'(cnt_q / CW'(10));
  assign cnt_ones = 4'(cnt_q % CW'(10));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: one instance with short phase times, one with defaults,
// both checked every cycle against a table-driven phase model.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clk_1024, emg, hold;
  logic [2:0] s_main, s_side, s_state, d_main, d_side, d_state;
  logic [3:0] s_tens, s_ones, d_tens, d_ones;

  traffic_light_ctrl #(.T_MG(5), .T_MY(2), .T_AR(1), .T_SG(4), .T_SY(2)) dut (
    .clk_1(clk), .rst(rst), .clk_1024(clk_1024), .emg(emg), .hold(hold),
    .main_rgy(s_main), .side_rgy(s_side), .cnt_tens(s_tens), .cnt_ones(s_ones),
    .state_o(s_state)
  );

  traffic_light_ctrl dut_dflt (
    .clk_1(clk), .rst(rst), .clk_1024(clk_1024), .emg(emg), .hold(hold),
    .main_rgy(d_main), .side_rgy(d_side), .cnt_tens(d_tens), .cnt_ones(d_ones),
    .state_o(d_state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] m;
    logic [2:0] s;
    logic [3:0] t;
    logic [3:0] o;
  } exp_t;

  // Model: phase index 0..5 walks the normal cycle, 6 is emergency.
  typedef struct packed {
    int ph;
    int rem;
    bit prev;
  } mdl_t;

  int dur_s [6] = '{5, 2, 1, 4, 2, 1};
  int dur_d [6] = '{30, 3, 2, 20, 3, 2};

  exp_t q_s[$];
  exp_t q_d[$];
  mdl_t ms, md;
  int   wave_cnt;
  int   cyc_no;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 1'b0;
  bit   r_v, e_v, h_v;

  function automatic int dur_of(input bit dflt, input int ph);
    return dflt ? dur_d[ph] : dur_s[ph];
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit dflt, input bit r,
                                input bit lvl, input bit e, input bit h);
    mdl_t n = m;
    bit   tick = lvl && !m.prev;
    if (r) begin
      n.ph = 0; n.rem = dur_of(dflt, 0); n.prev = 1'b0;
      return n;
    end
    n.prev = lvl;
    if (e) begin
      n.ph = 6; n.rem = 0;
    end else if (m.ph == 6) begin
      n.ph = 5; n.rem = dur_of(dflt, 5);
    end else if (!h && tick) begin
      if (m.rem == 1) begin
        n.ph  = (m.ph + 1) % 6;
        n.rem = dur_of(dflt, n.ph);
      end else begin
        n.rem = m.rem - 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(input mdl_t m);
    exp_t x;
    x.st = 3'(m.ph);
    x.m  = (m.ph == 0) ? 3'b001 : (m.ph == 1) ? 3'b010 : 3'b100;
    x.s  = (m.ph == 3) ? 3'b001 : (m.ph == 4) ? 3'b010 : 3'b100;
    x.t  = 4'(m.rem / 10);
    x.o  = 4'(m.rem % 10);
    return x;
  endfunction

  // Drive one cycle of stimulus and queue what both instances must show after the edge.
  task automatic cyc();
    clk_1024 = (wave_cnt % 20) >= 10;
    wave_cnt++;
    rst  = r_v;
    emg  = e_v;
    hold = h_v;
    ms = step(ms, 1'b0, r_v, clk_1024, e_v, h_v);
    md = step(md, 1'b1, r_v, clk_1024, e_v, h_v);
    q_s.push_back(expect_of(ms));
    q_d.push_back(expect_of(md));
    @(negedge clk);
  endtask

  task automatic run_until(input int ph, input int rem);
    int k = 0;
    while (!(ms.ph == ph && ms.rem == rem) && k < 3000) begin
      cyc();
      k++;
    end
    if (k >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_until: phase %0d rem %0d not reached, model at %0d/%0d",
               ph, rem, ms.ph, ms.rem);
    end
  endtask

  task automatic run_to_rise();
    while ((wave_cnt % 20) != 10) cyc();
  endtask

  initial begin
    r_v = 1'b1; e_v = 1'b0; h_v = 1'b0;
    wave_cnt = 0;
    ms = '0; md = '0;
    repeat (3) cyc();
    r_v = 1'b0;
    // free run: covers a full small-timer cycle and default countdown through 10
    repeat (400) cyc();
    // hold across three rises during SG with 3 left
    run_until(3, 3);
    h_v = 1'b1;
    repeat (60) cyc();
    h_v = 1'b0;
    repeat (25) cyc();
    // emergency during MG with 4 left
    run_until(0, 4);
    e_v = 1'b1;
    repeat (50) cyc();
    e_v = 1'b0;
    repeat (60) cyc();
    // emergency and hold together on a rise
    run_to_rise();
    e_v = 1'b1; h_v = 1'b1;
    repeat (5) cyc();
    e_v = 1'b0; h_v = 1'b0;
    repeat (45) cyc();
    // reset pulse coinciding with a rise in SY, last second
    run_until(4, 1);
    run_to_rise();
    r_v = 1'b1;
    cyc();
    r_v = 1'b0;
    repeat (45) cyc();
    // exit EMG on the same cycle as a rise
    e_v = 1'b1;
    repeat (3) cyc();
    while ((wave_cnt % 20) != 9) cyc();
    cyc();
    e_v = 1'b0;
    repeat (45) cyc();
    // randomized mix
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) e_v = ~e_v;
      if ($urandom_range(0, 24) == 0) h_v = ~h_v;
      r_v = ($urandom_range(0, 499) == 0);
      cyc();
    end
    r_v = 1'b0; e_v = 1'b0; h_v = 1'b0;
    repeat (60) cyc();
    drv_done = 1'b1;
  end

  // Monitor: outputs are valid every cycle, so each edge retires one queued expectation per instance.
  initial begin
    exp_t e, a;
    cyc_no = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        a = {s_state, s_main, s_side, s_tens, s_ones};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL small cyc=%0d: got st=%0d m=%b s=%b bcd=%0d/%0d want st=%0d m=%b s=%b bcd=%0d/%0d",
                   cyc_no, a.st, a.m, a.s, a.t, a.o, e.st, e.m, e.s, e.t, e.o);
        end
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        a = {d_state, d_main, d_side, d_tens, d_ones};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL dflt cyc=%0d: got st=%0d m=%b s=%b bcd=%0d/%0d want st=%0d m=%b s=%b bcd=%0d/%0d",
                   cyc_no, a.st, a.m, a.s, a.t, a.o, e.st, e.m, e.s, e.t, e.o);
        end
      end
      if (drv_done && q_s.size() == 0 && q_d.size() == 0) break;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d checks done", n_tests);
    $fatal(1, "timeout");
  end

endmodule
